// File: rtl/tracking_frame_collector.sv
// tracking_frame_collector: byte-stream frame collector for tracking mode.
// Matches a 0..2 byte header, buffers a frame of run-time length, verifies a
// modulo-256 checksum and writes 1..4 big-endian 32-bit fields to the BRAM
// writer through the run/idle handshake.
// Optional macro TRACKING_FRAME_CHECKSUM_EN: when defined the trailing
// checksum byte is verified; when undefined CHECK always passes.
module tracking_frame_collector #(
  parameter int MAX_FRAME_LEN = 32,
  parameter int ADDR_W        = 10,
  parameter int GAP_TIMEOUT   = 4096,
  parameter int WRITE_TIMEOUT = 8,
  parameter int LEN_W         = $clog2(MAX_FRAME_LEN + 1)
) (
  input  logic              system_clk,
  input  logic              reset,
  input  logic [1:0]        cfg_hdr_len,
  input  logic [7:0]        cfg_hdr0,
  input  logic [7:0]        cfg_hdr1,
  input  logic [LEN_W-1:0]  cfg_frame_len,
  input  logic [LEN_W-1:0]  cfg_field_start,
  input  logic [2:0]        cfg_field_count,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic              rx_complete,
  input  logic [7:0]        rx_data,
  input  logic              bram_write_idle,
  output logic              bram_write_run,
  output logic              bram_mode,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_data,
  output logic              frame_done,
  output logic [2:0]        collection_error,
  output logic [15:0]       frame_count
);

  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam int WT_W  = $clog2(WRITE_TIMEOUT + 1);
  localparam int CW    = LEN_W + 4;

  typedef enum logic [2:0] {
    IDLE, HEADER, PAYLOAD, CHECK, WR_START, WR_WAIT, DONE
  } state_t;

  state_t            state;
  logic              rx_prev;
  logic              strobe;
  logic [LEN_W-1:0]  byte_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [WT_W-1:0]   wr_cnt;
  logic [1:0]        k_q;
  logic [1:0]        wr_k;
  logic [7:0]        frame_buf [MAX_FRAME_LEN];

  logic [7:0]        hdr0_q;
  logic [7:0]        hdr1_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  start_q;
  logic [2:0]        count_q;
  logic [ADDR_W-1:0] base_q;

  logic              cfg_valid;
  logic [CW-1:0]     cfg_need;
  logic              sum_ok;
  logic [LEN_W-1:0]  field_pos;
  logic [31:0]       field_word;

  assign strobe = rx_complete & ~rx_prev;

  // Write outputs are registered on entry to WR_START, so the field selected
  // here is the one about to be written: 0 from CHECK, k+1 from WR_WAIT.
  assign wr_k      = (state == WR_WAIT) ? k_q + 2'd1 : 2'd0;
  assign field_pos = start_q + LEN_W'({wr_k, 2'b00});

  // Frame configuration sanity check on the live cfg_* ports.
  always_comb begin
    cfg_need  = CW'(cfg_field_start) + CW'({cfg_field_count, 2'b00}) + CW'(1);
    cfg_valid = (cfg_frame_len >= LEN_W'(2)) &&
                (cfg_frame_len <= LEN_W'(MAX_FRAME_LEN)) &&
                (cfg_hdr_len <= 2'd2) &&
                (cfg_field_count >= 3'd1) && (cfg_field_count <= 3'd4) &&
                (cfg_field_start >= LEN_W'(cfg_hdr_len)) &&
                (cfg_need <= CW'(cfg_frame_len));
  end

`ifdef TRACKING_FRAME_CHECKSUM_EN
  logic [7:0] sum_acc;
  logic [7:0] sum_rx;

  // Modulo-256 sum of bytes 0..len-2 against the trailing checksum byte.
  always_comb begin
    sum_acc = '0;
    sum_rx  = '0;
    for (int unsigned i = 0; i < MAX_FRAME_LEN; i++) begin
      if (LEN_W'(i) < len_q - LEN_W'(1)) sum_acc = sum_acc + frame_buf[i];
      if (LEN_W'(i) == len_q - LEN_W'(1)) sum_rx = frame_buf[i];
    end
    sum_ok = (sum_acc == sum_rx);
  end
`else
  // Checksum verification disabled: the trailing byte is ignored.
  always_comb begin
    sum_ok = 1'b1;
  end
`endif

  // Gather the four big-endian bytes of the selected field.
  always_comb begin
    field_word = '0;
    for (int unsigned i = 0; i < MAX_FRAME_LEN; i++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        if (LEN_W'(i) == field_pos + LEN_W'(j)) field_word[8*(3-j) +: 8] = frame_buf[i];
      end
    end
  end

  // Frame collection and BRAM write sequencing.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      state            <= IDLE;
      rx_prev          <= 1'b0;
      byte_idx         <= '0;
      gap_cnt          <= '0;
      wr_cnt           <= '0;
      k_q              <= '0;
      hdr0_q           <= '0;
      hdr1_q           <= '0;
      len_q            <= '0;
      start_q          <= '0;
      count_q          <= '0;
      base_q           <= '0;
      bram_write_run   <= 1'b0;
      bram_mode        <= 1'b0;
      bram_addr        <= '0;
      bram_data        <= '0;
      frame_done       <= 1'b0;
      collection_error <= '0;
      frame_count      <= '0;
    end else begin
      rx_prev        <= rx_complete;
      bram_write_run <= 1'b0;
      frame_done     <= 1'b0;

      // A byte arriving while a frame is being checked or written is lost.
      if (strobe && (state inside {CHECK, WR_START, WR_WAIT, DONE}))
        collection_error <= 3'd5;

      case (state)
        IDLE: begin
          gap_cnt <= '0;
          if (strobe) begin
            if (!cfg_valid) begin
              collection_error <= 3'd2;
            end else begin
              hdr0_q  <= cfg_hdr0;
              hdr1_q  <= cfg_hdr1;
              len_q   <= cfg_frame_len;
              start_q <= cfg_field_start;
              count_q <= cfg_field_count;
              base_q  <= cfg_base_addr;
              if (cfg_hdr_len == 2'd0 || rx_data == cfg_hdr0) begin
                frame_buf[0] <= rx_data;
                byte_idx     <= LEN_W'(1);
                state        <= (cfg_hdr_len == 2'd2) ? HEADER : PAYLOAD;
              end else begin
                collection_error <= 3'd1;
              end
            end
          end
        end

        HEADER: begin
          if (strobe) begin
            gap_cnt <= '0;
            if (rx_data == hdr1_q) begin
              frame_buf[1] <= rx_data;
              byte_idx     <= LEN_W'(2);
              state        <= PAYLOAD;
            end else begin
              collection_error <= 3'd1;
              if (rx_data == hdr0_q) begin
                frame_buf[0] <= rx_data;
                byte_idx     <= LEN_W'(1);
              end else begin
                byte_idx <= '0;
                state    <= IDLE;
              end
            end
          end else if (gap_cnt == GAP_W'(GAP_TIMEOUT - 1)) begin
            collection_error <= 3'd6;
            byte_idx         <= '0;
            state            <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        PAYLOAD: begin
          if (strobe) begin
            gap_cnt <= '0;
            for (int unsigned i = 0; i < MAX_FRAME_LEN; i++) begin
              if (LEN_W'(i) == byte_idx) frame_buf[i] <= rx_data;
            end
            byte_idx <= byte_idx + LEN_W'(1);
            if (byte_idx == len_q - LEN_W'(1)) state <= CHECK;
          end else if (gap_cnt == GAP_W'(GAP_TIMEOUT - 1)) begin
            collection_error <= 3'd6;
            byte_idx         <= '0;
            state            <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        CHECK: begin
          byte_idx <= '0;
          if (!sum_ok) begin
            collection_error <= 3'd3;
            state            <= IDLE;
          end else begin
            k_q            <= wr_k;
            bram_mode      <= 1'b1;
            bram_addr      <= base_q + ADDR_W'(wr_k);
            bram_data      <= field_word;
            bram_write_run <= 1'b1;
            state          <= WR_START;
          end
        end

        WR_START: begin
          wr_cnt <= '0;
          state  <= WR_WAIT;
        end

        WR_WAIT: begin
          if (bram_write_idle) begin
            if ({1'b0, k_q} + 3'd1 < count_q) begin
              k_q            <= wr_k;
              bram_addr      <= base_q + ADDR_W'(wr_k);
              bram_data      <= field_word;
              bram_write_run <= 1'b1;
              state          <= WR_START;
            end else begin
              frame_done       <= 1'b1;
              frame_count      <= frame_count + 16'd1;
              collection_error <= 3'd0;
              bram_mode        <= 1'b0;
              state            <= DONE;
            end
          end else if (wr_cnt == WT_W'(WRITE_TIMEOUT - 1)) begin
            collection_error <= 3'd4;
            bram_mode        <= 1'b0;
            k_q              <= '0;
            state            <= IDLE;
          end else begin
            wr_cnt <= wr_cnt + WT_W'(1);
          end
        end

        DONE: begin
          k_q   <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
